read_stage_rr_arbiter_pipe: RTL and testbench

- Parametrised N-input round-robin arbiter for VRF read-stage requests (vs, offset, groupIndex, readSource, instructionIndex).
- Successor to the single-input pass-through read-stage arbiter.
- Adds true round-robin selection across NUM_IN requesters and a 2-entry registered output buffer, which breaks the ready/valid timing path between requesters and the VRF read port.
- Forwards groupIndex on the output; the previous generation dropped it.

---
 rtl/read_stage_rr_arbiter_pipe.sv | 138 +++++++++++++
 tb/tb_read_stage_rr_arbiter_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/read_stage_rr_arbiter_pipe.sv
// Round-robin arbiter over NUM_IN VRF read-stage requesters feeding a 2-entry registered output buffer.
// Optional `define READ_STAGE_ARB_PERF_EN adds the saturating perf_conflict_count output.
module read_stage_rr_arbiter_pipe #(
    parameter int NUM_IN   = 4,
    parameter int VS_W     = 5,
    parameter int OFFSET_W = 2,
    parameter int GROUP_W  = 4,
    parameter int SRC_W    = 4,
    parameter int INST_W   = 3,
    localparam int ID_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [NUM_IN*VS_W-1:0]       in_vs,
    input  logic [NUM_IN*OFFSET_W-1:0]   in_offset,
    input  logic [NUM_IN*GROUP_W-1:0]    in_group_index,
    input  logic [NUM_IN*SRC_W-1:0]      in_read_source,
    input  logic [NUM_IN*INST_W-1:0]     in_instruction_index,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [VS_W-1:0]              out_vs,
    output logic [OFFSET_W-1:0]          out_offset,
    output logic [GROUP_W-1:0]           out_group_index,
    output logic [SRC_W-1:0]             out_read_source,
    output logic [INST_W-1:0]            out_instruction_index,
    output logic [ID_W-1:0]              out_grant_id
`ifdef READ_STAGE_ARB_PERF_EN
    ,
    output logic [15:0]                  perf_conflict_count
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on
    // ready, and a producer holds its payload stable while valid is high and ready is low.

    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant_id;
    logic                grant_found;
    logic [NUM_IN-1:0]   grant_onehot;
    logic [1:0]          count;
    logic                rd_idx;
    logic                wr_idx;
    logic                enq;
    logic                deq;

    logic [VS_W-1:0]     buf_vs   [2];
    logic [OFFSET_W-1:0] buf_off  [2];
    logic [GROUP_W-1:0]  buf_grp  [2];
    logic [SRC_W-1:0]    buf_src  [2];
    logic [INST_W-1:0]   buf_inst [2];
    logic [ID_W-1:0]     buf_id   [2];

    always_comb begin
        int idx;
        idx          = 0;
        grant_id     = '0;
        grant_found  = 1'b0;
        grant_onehot = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!grant_found && in_valid[idx]) begin
                grant_found       = 1'b1;
                grant_id          = ID_W'(idx);
                grant_onehot[idx] = 1'b1;
            end
        end
    end

    // A full buffer refuses input even when it drains this cycle; the slot frees next cycle.
    assign in_ready  = grant_onehot & {NUM_IN{count != 2'd2}};
    assign enq       = |(in_valid & in_ready);
    assign out_valid = (count != 2'd0);
    assign deq       = out_valid && out_ready;
    assign wr_idx    = rd_idx ^ count[0];

    assign out_vs                = buf_vs[rd_idx];
    assign out_offset            = buf_off[rd_idx];
    assign out_group_index       = buf_grp[rd_idx];
    assign out_read_source       = buf_src[rd_idx];
    assign out_instruction_index = buf_inst[rd_idx];
    assign out_grant_id          = buf_id[rd_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr    <= '0;
            count  <= 2'd0;
            rd_idx <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                buf_vs[e]   <= '0;
                buf_off[e]  <= '0;
                buf_grp[e]  <= '0;
                buf_src[e]  <= '0;
                buf_inst[e] <= '0;
                buf_id[e]   <= '0;
            end
        end else begin
            if (enq) begin
                buf_vs[wr_idx]   <= in_vs[grant_id*VS_W +: VS_W];
                buf_off[wr_idx]  <= in_offset[grant_id*OFFSET_W +: OFFSET_W];
                buf_grp[wr_idx]  <= in_group_index[grant_id*GROUP_W +: GROUP_W];
                buf_src[wr_idx]  <= in_read_source[grant_id*SRC_W +: SRC_W];
                buf_inst[wr_idx] <= in_instruction_index[grant_id*INST_W +: INST_W];
                buf_id[wr_idx]   <= grant_id;
                if (grant_id == ID_W'(NUM_IN - 1)) ptr <= '0;
                else                               ptr <= grant_id + 1'b1;
            end
            if (deq) rd_idx <= ~rd_idx;
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef READ_STAGE_ARB_PERF_EN
    int n_valid;

    always_comb begin
        n_valid = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_valid[i]) n_valid++;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_conflict_count <= 16'd0;
        end else if (enq && (n_valid >= 2) && (perf_conflict_count != 16'hFFFF)) begin
            perf_conflict_count <= perf_conflict_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_read_stage_rr_arbiter_pipe.sv
// Self-checking bench for read_stage_rr_arbiter_pipe: directed scenarios plus random traffic
// against a queue-based reference model of the arbiter and its 2-deep buffer.
module tb_read_stage_rr_arbiter_pipe;

    localparam int NUM_IN   = 4;
    localparam int VS_W     = 5;
    localparam int OFFSET_W = 2;
    localparam int GROUP_W  = 4;
    localparam int SRC_W    = 4;
    localparam int INST_W   = 3;
    localparam int ID_W     = 2;
    localparam int ENT_W    = ID_W + INST_W + SRC_W + GROUP_W + OFFSET_W + VS_W;

    logic                       clock;
    logic                       reset;
    logic [NUM_IN-1:0]          in_valid;
    logic [NUM_IN-1:0]          in_ready;
    logic [NUM_IN*VS_W-1:0]     in_vs;
    logic [NUM_IN*OFFSET_W-1:0] in_offset;
    logic [NUM_IN*GROUP_W-1:0]  in_group_index;
    logic [NUM_IN*SRC_W-1:0]    in_read_source;
    logic [NUM_IN*INST_W-1:0]   in_instruction_index;
    logic                       out_valid;
    logic                       out_ready;
    logic [VS_W-1:0]            out_vs;
    logic [OFFSET_W-1:0]        out_offset;
    logic [GROUP_W-1:0]         out_group_index;
    logic [SRC_W-1:0]           out_read_source;
    logic [INST_W-1:0]          out_instruction_index;
    logic [ID_W-1:0]            out_grant_id;
`ifdef READ_STAGE_ARB_PERF_EN
    logic [15:0]                perf_conflict_count;
`endif

    read_stage_rr_arbiter_pipe #(
        .NUM_IN(NUM_IN), .VS_W(VS_W), .OFFSET_W(OFFSET_W),
        .GROUP_W(GROUP_W), .SRC_W(SRC_W), .INST_W(INST_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_vs(in_vs),
        .in_offset(in_offset),
        .in_group_index(in_group_index),
        .in_read_source(in_read_source),
        .in_instruction_index(in_instruction_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vs(out_vs),
        .out_offset(out_offset),
        .out_group_index(out_group_index),
        .out_read_source(out_read_source),
        .out_instruction_index(out_instruction_index),
        .out_grant_id(out_grant_id)
`ifdef READ_STAGE_ARB_PERF_EN
        ,
        .perf_conflict_count(perf_conflict_count)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model state
    logic [ENT_W-1:0] exp_q[$];
    int               m_ptr;
    int               m_perf;
    int               n_checks;
    int               n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NUM_IN-1:0] v);
        for (int k = 0; k < NUM_IN; k++) begin
            int c = (m_ptr + k) % NUM_IN;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic randomize_payload();
        logic [31:0] r;
        r = $urandom(); in_vs                = r[NUM_IN*VS_W-1:0];
        r = $urandom(); in_offset            = r[NUM_IN*OFFSET_W-1:0];
        r = $urandom(); in_group_index       = r[NUM_IN*GROUP_W-1:0];
        r = $urandom(); in_read_source       = r[NUM_IN*SRC_W-1:0];
        r = $urandom(); in_instruction_index = r[NUM_IN*INST_W-1:0];
    endtask

    task automatic model_flush();
        exp_q.delete();
        m_ptr  = 0;
        m_perf = 0;
    endtask

    // One cycle: entered at a falling edge, drives inputs, checks, then updates the model.
    task automatic step(input logic [NUM_IN-1:0] v, input logic rdy);
        int               g;
        logic [NUM_IN-1:0] exp_ready;
        logic [ENT_W-1:0] head;
        logic [ENT_W-1:0] ent;
        in_valid  = v;
        out_ready = rdy;
        #1;
        g = model_grant(v);
        exp_ready = (g >= 0 && exp_q.size() < 2) ? (NUM_IN'(1) << g) : '0;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check_eq("out_vs",   32'(out_vs),                32'(head[VS_W-1:0]));
            check_eq("out_off",  32'(out_offset),            32'(head[VS_W +: OFFSET_W]));
            check_eq("out_grp",  32'(out_group_index),       32'(head[VS_W+OFFSET_W +: GROUP_W]));
            check_eq("out_src",  32'(out_read_source),       32'(head[VS_W+OFFSET_W+GROUP_W +: SRC_W]));
            check_eq("out_inst", 32'(out_instruction_index), 32'(head[VS_W+OFFSET_W+GROUP_W+SRC_W +: INST_W]));
            check_eq("out_id",   32'(out_grant_id),          32'(head[ENT_W-1 -: ID_W]));
        end
`ifdef READ_STAGE_ARB_PERF_EN
        check_eq("perf", 32'(perf_conflict_count), 32'(m_perf));
`endif
        @(posedge clock);
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (g >= 0 && exp_ready != '0) begin
            ent = {ID_W'(g), in_instruction_index[g*INST_W +: INST_W],
                   in_read_source[g*SRC_W +: SRC_W], in_group_index[g*GROUP_W +: GROUP_W],
                   in_offset[g*OFFSET_W +: OFFSET_W], in_vs[g*VS_W +: VS_W]};
            exp_q.push_back(ent);
            m_ptr = (g + 1) % NUM_IN;
            if ($countones(v) >= 2 && m_perf < 16'hFFFF) m_perf++;
        end
        @(negedge clock);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_flush();
        in_valid  = '0;
        out_ready = 1'b0;
        randomize_payload();

        // reset held for 3 cycles, then idle
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_grant_id", 32'(out_grant_id), 32'd0);
        reset = 1'b1;
        repeat (3) step('0, 1'b1);

        // round-robin with all channels requesting: order 0,1,2,3,0,1
        for (int k = 0; k < 6; k++) begin
            randomize_payload();
            step(4'b1111, 1'b1);
            #1;
            check_eq("rr_order", 32'(out_grant_id), 32'(k % NUM_IN));
        end
`ifdef READ_STAGE_ARB_PERF_EN
        check_eq("perf_rr", 32'(perf_conflict_count), 32'd6);
`endif
        repeat (2) step('0, 1'b1);

        // single channel 2 with vs=17
        randomize_payload();
        in_vs[2*VS_W +: VS_W] = 5'd17;
        step(4'b0100, 1'b1);
        #1;
        check_eq("single_vs", 32'(out_vs), 32'd17);
        check_eq("single_id", 32'(out_grant_id), 32'd2);
        step('0, 1'b1);

        // backpressure: two enqueues then full and stable, then drain in order
        randomize_payload();
        repeat (5) step(4'b0011, 1'b0);
        repeat (3) step('0, 1'b1);

        // pointer skip/wrap: ptr=3 with only ch1 requesting
        step(4'b0100, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b1111, 1'b1);
        repeat (2) step('0, 1'b1);

        // asynchronous reset with a full buffer, between clock edges
        randomize_payload();
        repeat (2) step(4'b1111, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_grant_id", 32'(out_grant_id), 32'd0);
        model_flush();
        in_valid = '0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step(4'b1001, 1'b1);
        #1;
        check_eq("post_rst_id", 32'(out_grant_id), 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            randomize_payload();
            step(NUM_IN'($urandom_range(0, (1 << NUM_IN) - 1)), ($urandom_range(0, 3) != 0));
        end
        repeat (3) step('0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
